// File: rtl/sa_pkg.sv
// Shared types for the systolic-array feed path: FSM states, byte lane type, default array width.
package sa_pkg;

    localparam int unsigned SA_N = 8;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } sa_feed_state_t;

    typedef logic [7:0] sa_byte_t;

endpackage

// File: rtl/sa_addr_gen.sv
// Row address accumulator: load latches base and stride, step advances by stride (mod 2^ADDR_W).
module sa_addr_gen #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] stride,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] stride_q, stride_d;

    always_comb begin
        addr_d   = addr_q;
        stride_d = stride_q;
        if (load) begin
            addr_d   = base;
            stride_d = stride;
        end else if (step) begin
            addr_d = addr_q + stride_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            stride_q <= '0;
        end else begin
            addr_q   <= addr_d;
            stride_q <= stride_d;
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/sa_feed_ctrl.sv
// Read sequencer feeding the skew stage: walks a tile row by row, then drains the array.
// Optional build macro SA_FEED_PERF_EN adds the perf_cycles busy-cycle counter.
module sa_feed_ctrl
    import sa_pkg::*;
#(
    parameter int unsigned N         = SA_N,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned CNT_W     = 10,
    parameter int unsigned ARRAY_LAT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W-1:0]   addr_stride,
    input  logic [CNT_W-1:0]    num_rows,
    output logic                busy,
    output logic                done,
    output logic                sram_cen_n,
    output logic [ADDR_W-1:0]   sram_addr,
    input  logic [N*8-1:0]      sram_rdata,
    output logic                ren_n,
    output sa_byte_t [N-1:0]    data_out
`ifdef SA_FEED_PERF_EN
    ,
    output logic [31:0]         perf_cycles
`endif
);

    localparam int unsigned DRAIN_CYC = N - 1 + ARRAY_LAT;
    localparam int unsigned DRN_W     = $clog2(DRAIN_CYC + 1);

    sa_feed_state_t    state_q, state_d;
    logic [CNT_W-1:0]  row_q, row_d;
    logic [DRN_W-1:0]  drn_q, drn_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cen_n_q, cen_n_d;
    logic              load_c, step_c;
`ifdef SA_FEED_PERF_EN
    logic [31:0]       perf_q, perf_d;
`endif

    // Outputs are computed from the next state so they line up with the state they belong to.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        drn_d   = drn_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cen_n_d = 1'b1;
        load_c  = 1'b0;
        step_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load_c = 1'b1;
                    busy_d = 1'b1;
                    row_d  = num_rows;
                    if (num_rows == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = FETCH;
                        cen_n_d = 1'b0;
                    end
                end
            end
            FETCH: begin
                if (row_q == CNT_W'(1)) begin
                    state_d = DRAIN;
                    drn_d   = DRN_W'(DRAIN_CYC);
                end else begin
                    row_d   = row_q - CNT_W'(1);
                    cen_n_d = 1'b0;
                    step_c  = 1'b1;
                end
            end
            DRAIN: begin
                if (drn_q == DRN_W'(1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    drn_d = drn_q - DRN_W'(1);
                end
            end
            DONE: begin
                // An empty tile arrives here with done still low and spends one quiet busy cycle first.
                if (done_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef SA_FEED_PERF_EN
        perf_d = perf_q;
        if (state_q == IDLE && start) begin
            perf_d = '0;
        end else if (busy_q) begin
            perf_d = perf_q + 32'd1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            drn_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cen_n_q <= 1'b1;
`ifdef SA_FEED_PERF_EN
            perf_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            drn_q   <= drn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cen_n_q <= cen_n_d;
`ifdef SA_FEED_PERF_EN
            perf_q  <= perf_d;
`endif
        end
    end

    sa_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load_c),
        .step   (step_c),
        .base   (base_addr),
        .stride (addr_stride),
        .addr   (sram_addr)
    );

    assign busy       = busy_q;
    assign done       = done_q;
    assign sram_cen_n = cen_n_q;
    assign ren_n      = cen_n_q;
    assign data_out   = sram_rdata;
`ifdef SA_FEED_PERF_EN
    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_sa_feed_ctrl.sv
// Bench for sa_feed_ctrl: tile-level reference model, directed scenarios and randomized traffic.
module tb_sa_feed_ctrl;

    localparam int unsigned N   = 8;
    localparam int unsigned AW  = 10;
    localparam int unsigned CW  = 10;
    localparam int unsigned LAT = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [AW-1:0]     base_addr;
    logic [AW-1:0]     addr_stride;
    logic [CW-1:0]     num_rows;
    logic              busy;
    logic              done;
    logic              sram_cen_n;
    logic [AW-1:0]     sram_addr;
    logic [N*8-1:0]    sram_rdata;
    logic              ren_n;
    logic [N-1:0][7:0] data_out;
`ifdef SA_FEED_PERF_EN
    logic [31:0]       perf_cycles;
`endif

    sa_feed_ctrl #(
        .N         (N),
        .ADDR_W    (AW),
        .CNT_W     (CW),
        .ARRAY_LAT (LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .addr_stride (addr_stride),
        .num_rows    (num_rows),
        .busy        (busy),
        .done        (done),
        .sram_cen_n  (sram_cen_n),
        .sram_addr   (sram_addr),
        .sram_rdata  (sram_rdata),
        .ren_n       (ren_n),
        .data_out    (data_out)
`ifdef SA_FEED_PERF_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at time %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Tile-level model: a tile accepted at cycle t0 reads in t0+1..t0+rows and finishes at t0+end.
    int            cyc = 0;
    bit            has_tile = 1'b0;
    int            t0, t_rows, t_end;
    logic [AW-1:0] t_base, t_stride;
    int            done_cyc = -1;
    logic [AW-1:0] addr_log[$];

    always @(posedge clk) begin
        int            k;
        bit            exp_read;
        logic [AW-1:0] exp_addr;
        int            exp_perf;
        if (rst_n && start && (!has_tile || (cyc - t0 > t_end))) begin
            has_tile = 1'b1;
            t0       = cyc;
            t_rows   = int'(num_rows);
            t_end    = (num_rows == 0) ? 2 : int'(num_rows) + int'(N) - 1 + int'(LAT) + 1;
            t_base   = base_addr;
            t_stride = addr_stride;
        end
        cyc++;
        #1;
        if (!rst_n) begin
            has_tile = 1'b0;
            chk("rst_addr", 64'(sram_addr), 64'(0));
        end
        k        = cyc - t0;
        exp_read = has_tile && k >= 1 && k <= t_rows;
        exp_addr = AW'(int'(t_base) + (k - 1) * int'(t_stride));
        chk("busy",  64'(busy),       64'(has_tile && k >= 1 && k <= t_end));
        chk("done",  64'(done),       64'(has_tile && k == t_end));
        chk("cen_n", 64'(sram_cen_n), 64'(!exp_read));
        chk("ren_n", 64'(ren_n),      64'(!exp_read));
        if (exp_read) chk("addr", 64'(sram_addr), 64'(exp_addr));
        chk("data_out", 64'(data_out), 64'(sram_rdata));
        exp_perf = !has_tile ? 0 : ((k - 1 < t_end) ? k - 1 : t_end);
`ifdef SA_FEED_PERF_EN
        chk("perf", 64'(perf_cycles), 64'(exp_perf));
`else
        exp_perf = exp_perf + 0;
`endif
        if (done) done_cyc = cyc;
        if (!sram_cen_n) addr_log.push_back(sram_addr);
    end

    // Drive one cycle's inputs shortly after the active edge.
    task automatic drive(input logic st, input logic [AW-1:0] b, input logic [AW-1:0] s,
                         input logic [CW-1:0] r);
        @(posedge clk);
        #2;
        start       = st;
        base_addr   = b;
        addr_stride = s;
        num_rows    = r;
        sram_rdata  = {$urandom, $urandom};
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, AW'($urandom), AW'($urandom), CW'($urandom));
    endtask

    // Asynchronous reset in mid-cycle; outputs must drop before the next edge.
    task automatic mid_reset();
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_busy",  64'(busy),       64'(0));
        chk("async_done",  64'(done),       64'(0));
        chk("async_cen_n", 64'(sram_cen_n), 64'(1));
        chk("async_ren_n", 64'(ren_n),      64'(1));
        chk("async_addr",  64'(sram_addr),  64'(0));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    int            t;
    logic [AW-1:0] exp4[4];

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        base_addr   = '0;
        addr_stride = '0;
        num_rows    = '0;
        sram_rdata  = '0;
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // Basic tile: 4 rows from 0x10, done 20 cycles after start
        addr_log.delete();
        done_cyc = -1;
        drive(1'b1, AW'('h10), AW'(1), CW'(4));
        t = cyc;
        idle(24);
        chk("t1_done_lat", 64'(done_cyc - t), 64'(20));
        chk("t1_nreads", 64'(addr_log.size()), 64'(4));
        exp4 = '{AW'('h10), AW'('h11), AW'('h12), AW'('h13)};
        for (int i = 0; i < 4 && i < addr_log.size(); i++) chk("t1_addr", 64'(addr_log[i]), 64'(exp4[i]));
`ifdef SA_FEED_PERF_EN
        chk("t1_perf", 64'(perf_cycles), 64'(20));
`endif

        // Wrap-around addressing
        addr_log.delete();
        drive(1'b1, AW'('h3FE), AW'(1), CW'(4));
        idle(24);
        exp4 = '{AW'('h3FE), AW'('h3FF), AW'('h000), AW'('h001)};
        chk("t2_nreads", 64'(addr_log.size()), 64'(4));
        for (int i = 0; i < 4 && i < addr_log.size(); i++) chk("t2_addr", 64'(addr_log[i]), 64'(exp4[i]));

        // Empty tile
        addr_log.delete();
        done_cyc = -1;
        drive(1'b1, AW'('h55), AW'(3), CW'(0));
        t = cyc;
        idle(6);
        chk("t3_done_lat", 64'(done_cyc - t), 64'(2));
        chk("t3_nreads", 64'(addr_log.size()), 64'(0));

        // Starts during FETCH and in the done cycle are dropped; the next cycle's start is taken
        drive(1'b1, AW'('h100), AW'(3), CW'(5));
        t = cyc;
        while (cyc < t + 23) begin
            int c;
            @(posedge clk);
            #2;
            c           = cyc;
            start       = (c == t + 2) || (c == t + 21) || (c == t + 22);
            base_addr   = AW'('h200);
            addr_stride = AW'(7);
            num_rows    = CW'(2);
            sram_rdata  = {$urandom, $urandom};
        end
        done_cyc = -1;
        drive(1'b0, '0, '0, '0);
        idle(20);
        chk("t4_done2", 64'(done_cyc - t), 64'(40));

        // Reset in the middle of FETCH abandons the tile, then a clean tile runs
        drive(1'b1, AW'('h20), AW'(2), CW'(6));
        idle(3);
        mid_reset();
        done_cyc = -1;
        idle(25);
        chk("t5_no_done", 64'(done_cyc), 64'(-1));
        drive(1'b1, AW'('h30), AW'(1), CW'(3));
        t = cyc;
        idle(22);
        chk("t5_done_lat", 64'(done_cyc - t), 64'(19));

        // Randomized traffic with overlapping start requests and occasional resets
        for (int i = 0; i < 2500; i++) begin
            drive(($urandom_range(0, 3) == 0), AW'($urandom), AW'($urandom),
                  ($urandom_range(0, 5) == 0) ? CW'($urandom_range(13, 40)) : CW'($urandom_range(0, 12)));
            if ($urandom_range(0, 299) == 0) mid_reset();
        end
        idle(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
